press_judge: RTL

Round-scoring stage that sits directly downstream of the game-control FSM and the debounced NES button bank. It takes the 3-bit target button chosen for the current round and the 8-bit debounced button vector, and judges the first fresh press inside a timeout window as a hit, a wrong press or a timeout. It maintains the saturating player score that drives the point seven-segment display and returns a one-cycle `checkdone` pulse so the control FSM can advance to the next round.

---
 rtl/press_judge_if.sv | 22 ++
 rtl/press_judge.sv | 113 +++++++++++
 2 files changed

// File: rtl/press_judge_if.sv
// Round-judging handshake between the control FSM/button bank (master) and press_judge (slave).
interface press_judge_if;
  logic       enable;
  logic       clear;
  logic [2:0] target;
  logic [7:0] buttons;
  logic       checkdone;
  logic       hit;
  logic       miss;
  logic       timeout;
  logic [7:0] score;

  modport master (
    output enable, clear, target, buttons,
    input  checkdone, hit, miss, timeout, score
  );

  modport slave (
    input  enable, clear, target, buttons,
    output checkdone, hit, miss, timeout, score
  );
endinterface

// File: rtl/press_judge.sv
// Judges the first fresh press of a round as hit/miss/timeout and keeps a saturating score.
// Result pulses and score register on the judging edge; no input-to-output combinational path.
module press_judge #(
  parameter int SCORE_MAX      = 99,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         drst,
  press_judge_if.slave pj
);

  localparam int             CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     SMAX = SCORE_MAX[7:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_score;
  logic          r_checkdone;
  logic          r_hit;
  logic          r_miss;
  logic          r_timeout;

  logic [7:0] w_want;
  logic       w_press;
  logic       w_expire;
  logic [7:0] w_inc;
  logic [7:0] w_dec;

  assign w_want   = 8'd1 << pj.target;
  assign w_press  = |pj.buttons;
  assign w_expire = (r_cnt == LAST);
  assign w_inc    = (r_score >= SMAX) ? SMAX : r_score + 8'd1;
  assign w_dec    = (r_score == 8'd0) ? 8'd0 : r_score - 8'd1;

  always_ff @(posedge clk or negedge drst) begin
    if (!drst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_score     <= '0;
      r_checkdone <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_checkdone <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;

      case (r_state)
        S_IDLE: begin
          if (pj.enable) r_state <= S_ARM;
        end

        // A button still held from the previous round must be released first.
        S_ARM: begin
          if (!pj.enable)   r_state <= S_IDLE;
          else if (!w_press) r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (!pj.enable) begin
            r_state <= S_IDLE;
          end else if (w_press) begin
            r_state     <= S_DONE;
            r_checkdone <= 1'b1;
            if (pj.buttons == w_want) begin
              r_hit   <= 1'b1;
              r_score <= w_inc;
            end else begin
              r_miss  <= 1'b1;
              r_score <= w_dec;
            end
          end else if (w_expire) begin
            r_state     <= S_DONE;
            r_checkdone <= 1'b1;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: r_state <= S_HOLD;

        S_HOLD: begin
          if (!pj.enable) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase

      // Clear overrides any score update from the same edge.
      if (pj.clear) r_score <= '0;
    end
  end

  assign pj.checkdone = r_checkdone;
  assign pj.hit       = r_hit;
  assign pj.miss      = r_miss;
  assign pj.timeout   = r_timeout;
  assign pj.score     = r_score;

endmodule
